// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I decode/execute control pipeline.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLT    = 4'b0101,
        ALU_SLTU   = 4'b0110,
        ALU_SLL    = 4'b0111,
        ALU_SRL    = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_MUL    = 4'b1011,
        ALU_MULH   = 4'b1100,
        ALU_MULHSU = 4'b1101,
        ALU_MULHU  = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_ZERO = 2'b10
    } srca_e;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_U   = 3'b011,
        IMM_J   = 3'b100,
        IMM_BAD = 3'b111
    } imm_src_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BAD
    } op_class_e;

    // Everything carried across the D/E boundary; all-zero is a bubble.
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       regwrite;
        logic       memwrite;
        res_src_e   resultsrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        srca_e      alusrca;
        logic       alusrcb;
        alu_op_e    alucontrol;
        logic [2:0] funct3;
    } ctrl_t;

    // funct3 -> ALU op for the base register/immediate arithmetic group.
    function automatic alu_op_e base_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// ALU operation decoder; also owns all funct3/funct7 legality checks.
module ctrl_alu_dec
    import ctrl_pkg::*;
#(
    parameter bit SUPPORT_M = 1'b0
) (
    input  op_class_e  op_class_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    alu_op_o,
    output logic       illegal_o
);

    // Select ALU op per opcode class and flag encodings that are not defined.
    always_comb begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
        case (op_class_i)
            CLS_R: begin
                case (funct7_i)
                    7'b0000000: alu_op_o = base_alu_op(funct3_i);
                    7'b0100000: begin
                        if (funct3_i == 3'b000)      alu_op_o = ALU_SUB;
                        else if (funct3_i == 3'b101) alu_op_o = ALU_SRA;
                        else                         illegal_o = 1'b1;
                    end
                    7'b0000001: begin
                        if (SUPPORT_M && !funct3_i[2]) begin
                            case (funct3_i[1:0])
                                2'b00:   alu_op_o = ALU_MUL;
                                2'b01:   alu_op_o = ALU_MULH;
                                2'b10:   alu_op_o = ALU_MULHSU;
                                default: alu_op_o = ALU_MULHU;
                            endcase
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            CLS_I: begin
                alu_op_o = base_alu_op(funct3_i);
                if (funct3_i == 3'b001 && funct7_i != 7'b0000000) illegal_o = 1'b1;
                if (funct3_i == 3'b101) begin
                    if (funct7_i == 7'b0100000)      alu_op_o  = ALU_SRA;
                    else if (funct7_i != 7'b0000000) illegal_o = 1'b1;
                end
            end
            CLS_LOAD:  illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
            CLS_STORE: illegal_o = funct3_i[2] || (funct3_i[1:0] == 2'b11);
            CLS_BRANCH: begin
                case (funct3_i[2:1])
                    2'b00:   alu_op_o  = ALU_SUB;
                    2'b10:   alu_op_o  = ALU_SLT;
                    2'b11:   alu_op_o  = ALU_SLTU;
                    default: illegal_o = 1'b1;
                endcase
            end
            CLS_JALR:                   illegal_o = (funct3_i != 3'b000);
            CLS_LUI, CLS_AUIPC, CLS_JAL: illegal_o = 1'b0;
            default:                    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// RV32I control unit: decodes in D, drives ImmSrc combinationally and
// registers the remaining control into the D/E boundary.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter bit SUPPORT_M = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    output logic [2:0]           immsrc_d,
    output logic                 valid_e,
    output logic                 regwrite_e,
    output logic                 memwrite_e,
    output logic [1:0]           resultsrc_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic [1:0]           alusrca_e,
    output logic                 alusrcb_e,
    output logic [ALUCTRL_W-1:0] alucontrol_e,
    output logic [2:0]           funct3_e,
    output logic                 illegal_e,
    output logic [CNT_W-1:0]     illegal_cnt
);

    op_class_e       op_class;
    alu_op_e         alu_op;
    logic            alu_illegal;
    imm_src_e        imm_src;
    ctrl_t           dec;
    ctrl_t           e_d, e_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Register/immediate field bits are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^{instr_d[24:15], instr_d[11:7]};

    // Classify the major opcode.
    always_comb begin
        case (instr_d[6:0])
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_BRANCH: op_class = CLS_BRANCH;
            OP_LUI:    op_class = CLS_LUI;
            OP_AUIPC:  op_class = CLS_AUIPC;
            OP_JAL:    op_class = CLS_JAL;
            OP_JALR:   op_class = CLS_JALR;
            default:   op_class = CLS_BAD;
        endcase
    end

    ctrl_alu_dec #(
        .SUPPORT_M (SUPPORT_M)
    ) u_alu_dec (
        .op_class_i (op_class),
        .funct3_i   (instr_d[14:12]),
        .funct7_i   (instr_d[31:25]),
        .alu_op_o   (alu_op),
        .illegal_o  (alu_illegal)
    );

    // Main decode; illegal encodings collapse to a flagged no-op, and an
    // empty slot (valid_d=0) collapses to a plain bubble.
    always_comb begin
        dec            = '0;
        imm_src        = IMM_I;  // R-type has no immediate; value is don't-care
        dec.valid      = 1'b1;
        dec.funct3     = instr_d[14:12];
        dec.alucontrol = alu_op;
        case (op_class)
            CLS_R:     dec.regwrite = 1'b1;
            CLS_I: begin
                dec.regwrite = 1'b1;
                dec.alusrcb  = 1'b1;
            end
            CLS_LOAD: begin
                dec.regwrite  = 1'b1;
                dec.alusrcb   = 1'b1;
                dec.resultsrc = RES_MEM;
            end
            CLS_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrcb  = 1'b1;
                imm_src      = IMM_S;
            end
            CLS_BRANCH: begin
                dec.branch = 1'b1;
                imm_src    = IMM_B;
            end
            CLS_LUI, CLS_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrca  = (op_class == CLS_LUI) ? SRCA_ZERO : SRCA_PC;
                dec.alusrcb  = 1'b1;
                imm_src      = IMM_U;
            end
            CLS_JAL: begin
                dec.jump      = 1'b1;
                dec.regwrite  = 1'b1;
                dec.resultsrc = RES_PC4;
                imm_src       = IMM_J;
            end
            CLS_JALR: begin
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.regwrite  = 1'b1;
                dec.alusrcb   = 1'b1;
                dec.resultsrc = RES_PC4;
            end
            default: ;
        endcase
        if (alu_illegal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec.funct3  = instr_d[14:12];
            imm_src     = IMM_BAD;
        end
        if (!valid_d) begin
            dec = '0;
        end
    end

    // Next E-stage contents and counter: flush beats stall beats capture.
    always_comb begin
        e_d   = dec;
        cnt_d = cnt_q;
        if (flush_e) begin
            e_d = '0;
        end else if (stall_e) begin
            e_d = e_q;
        end else if (dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // D/E pipeline register and saturating illegal counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end

    assign immsrc_d     = imm_src;
    assign valid_e      = e_q.valid;
    assign regwrite_e   = e_q.regwrite;
    assign memwrite_e   = e_q.memwrite;
    assign resultsrc_e  = e_q.resultsrc;
    assign branch_e     = e_q.branch;
    assign jump_e       = e_q.jump;
    assign jalr_e       = e_q.jalr;
    assign alusrca_e    = e_q.alusrca;
    assign alusrcb_e    = e_q.alusrcb;
    assign alucontrol_e = ALUCTRL_W'(e_q.alucontrol);
    assign funct3_e     = e_q.funct3;
    assign illegal_e    = e_q.illegal;
    assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (no-M with 2-bit counter, M with
// 5-bit ALU code) driven identically and checked against an instruction-level model.
module tb_ctrl_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = 32'h0;
    logic        valid_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;

    logic [2:0] a_imm, b_imm, a_f3, b_f3;
    logic       a_valid, a_rw, a_mw, a_br, a_jmp, a_jalr, a_sb, a_ill;
    logic       b_valid, b_rw, b_mw, b_br, b_jmp, b_jalr, b_sb, b_ill;
    logic [1:0] a_rs, a_sa, b_rs, b_sa;
    logic [3:0] a_alu;
    logic [4:0] b_alu;
    logic [1:0] a_cnt;
    logic [7:0] b_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.ALUCTRL_W(4), .SUPPORT_M(1'b0), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
        .stall_e(stall_e), .flush_e(flush_e), .immsrc_d(a_imm), .valid_e(a_valid),
        .regwrite_e(a_rw), .memwrite_e(a_mw), .resultsrc_e(a_rs), .branch_e(a_br),
        .jump_e(a_jmp), .jalr_e(a_jalr), .alusrca_e(a_sa), .alusrcb_e(a_sb),
        .alucontrol_e(a_alu), .funct3_e(a_f3), .illegal_e(a_ill), .illegal_cnt(a_cnt));

    ctrl_decode_pipe #(.ALUCTRL_W(5), .SUPPORT_M(1'b1), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
        .stall_e(stall_e), .flush_e(flush_e), .immsrc_d(b_imm), .valid_e(b_valid),
        .regwrite_e(b_rw), .memwrite_e(b_mw), .resultsrc_e(b_rs), .branch_e(b_br),
        .jump_e(b_jmp), .jalr_e(b_jalr), .alusrca_e(b_sa), .alusrcb_e(b_sb),
        .alucontrol_e(b_alu), .funct3_e(b_f3), .illegal_e(b_ill), .illegal_cnt(b_cnt));

    typedef struct packed {
        logic       valid, ill, rw, mw;
        logic [1:0] rs;
        logic       br, jmp, jalr;
        logic [1:0] sa;
        logic       sb;
        logic [3:0] alu;
        logic [2:0] f3;
        logic [2:0] imm;
    } exp_t;

    // What an instruction must do, written mnemonic by mnemonic.
    function automatic exp_t model(input logic [31:0] ins, input bit m);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        int base[8];
        base = '{0, 7, 5, 6, 4, 8, 3, 2};  // add sll slt sltu xor srl or and
        e = '0; f3 = ins[14:12]; f7 = ins[31:25]; ok = 1'b1;
        e.valid = 1'b1; e.f3 = f3;
        case (ins[6:0])
            7'h33: begin
                e.rw = 1'b1;
                if (f7 == 7'h00)                    e.alu = 4'(base[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd9;
                else if (f7 == 7'h01 && m && f3 <= 3'd3) e.alu = 4'(11 + int'(f3));
                else ok = 1'b0;
            end
            7'h13: begin
                e.rw = 1'b1; e.sb = 1'b1; e.alu = 4'(base[f3]);
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) e.alu = 4'd9;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'h03: begin e.rw = 1'b1; e.sb = 1'b1; e.rs = 2'd1; ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
            7'h23: begin e.mw = 1'b1; e.sb = 1'b1; e.imm = 3'd1; ok = (f3 <= 3'd2); end
            7'h63: begin
                e.br = 1'b1; e.imm = 3'd2; ok = (f3 != 3'd2 && f3 != 3'd3);
                e.alu = (f3 <= 3'd1) ? 4'd1 : ((f3 <= 3'd5) ? 4'd5 : 4'd6);
            end
            7'h37: begin e.rw = 1'b1; e.sa = 2'd2; e.sb = 1'b1; e.imm = 3'd3; end
            7'h17: begin e.rw = 1'b1; e.sa = 2'd1; e.sb = 1'b1; e.imm = 3'd3; end
            7'h6F: begin e.jmp = 1'b1; e.rw = 1'b1; e.rs = 2'd2; e.imm = 3'd4; end
            7'h67: begin e.jmp = 1'b1; e.jalr = 1'b1; e.rw = 1'b1; e.sb = 1'b1; e.rs = 2'd2; ok = (f3 == 3'd0); end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0; e.valid = 1'b1; e.ill = 1'b1; e.f3 = f3; e.imm = 3'd7;
        end
        return e;
    endfunction

    function automatic logic [31:0] pack_exp(input exp_t e, input int cnt);
        return {4'h0, e.valid, e.ill, e.rw, e.mw, e.rs, e.br, e.jmp, e.jalr,
                e.sa, e.sb, 1'b0, e.alu, e.f3, 8'(cnt)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t ea = '0, eb = '0, ta, tb;
    int   ca = 0, cb = 0;

    // Model of the E stage for both instances, compared every cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea = '0; eb = '0; ca = 0; cb = 0;
            #1;
        end else begin
            ta = model(instr_d, 1'b0);
            tb = model(instr_d, 1'b1);
            chk("a_immsrc", {29'h0, a_imm}, {29'h0, ta.imm});
            chk("b_immsrc", {29'h0, b_imm}, {29'h0, tb.imm});
            if (flush_e) begin
                ea = '0; eb = '0;
            end else if (!stall_e) begin
                ea = valid_d ? ta : '0;
                eb = valid_d ? tb : '0;
                if (ea.ill) ca = (ca < 3) ? ca + 1 : 3;
                if (eb.ill) cb = (cb < 255) ? cb + 1 : 255;
            end
            #2;
        end
        chk("a_estage", {4'h0, a_valid, a_ill, a_rw, a_mw, a_rs, a_br, a_jmp, a_jalr,
                         a_sa, a_sb, 1'b0, a_alu, a_f3, 6'h0, a_cnt}, pack_exp(ea, ca));
        chk("b_estage", {4'h0, b_valid, b_ill, b_rw, b_mw, b_rs, b_br, b_jmp, b_jalr,
                         b_sa, b_sb, b_alu, b_f3, b_cnt}, pack_exp(eb, cb));
    end

    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        @(negedge clk);
        instr_d = ins; valid_d = v; stall_e = st; flush_e = fl;
        @(posedge clk);
        #3;
    endtask

    localparam logic [31:0] I_SUB  = 32'h40208133, I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_AUI  = 32'h00001097, I_JALR = 32'h000080E7;
    localparam logic [31:0] I_BLTU = 32'h0020E463, I_MUL  = 32'h02208133;
    localparam logic [31:0] I_SW   = 32'h0020A223, I_LW   = 32'h0040A103;
    localparam logic [31:0] I_SRAI = 32'h4010D093, I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_ADDI = 32'h00500093, I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_LDX  = 32'h0000B003, I_BRX  = 32'h0020A063;
    localparam logic [31:0] I_SLLX = 32'h02009093;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        step(I_SUB, 1, 0, 0);
        chk("sub_regwrite", {31'h0, a_rw}, 32'd1);
        chk("sub_alusrcb", {31'h0, a_sb}, 32'd0);
        chk("sub_alu", {28'h0, a_alu}, 32'h1);
        chk("sub_illegal", {31'h0, a_ill}, 32'd0);

        step(I_LUI, 1, 0, 0);
        chk("lui_immsrc", {29'h0, a_imm}, 32'd3);
        chk("lui_alusrca", {30'h0, a_sa}, 32'd2);
        chk("lui_alusrcb", {31'h0, a_sb}, 32'd1);
        step(I_AUI, 1, 0, 0);
        chk("auipc_alusrca", {30'h0, a_sa}, 32'd1);
        step(I_JALR, 1, 0, 0);
        chk("jalr_ctl", {28'h0, a_jmp, a_jalr, a_rs}, 32'b1110);
        step(I_BLTU, 1, 0, 0);
        chk("bltu_branch", {31'h0, a_br}, 32'd1);
        chk("bltu_alu", {28'h0, a_alu}, 32'h6);
        chk("bltu_funct3", {29'h0, a_f3}, 32'd6);
        step(I_SW, 1, 0, 0);
        step(I_LW, 1, 0, 0);
        step(I_SRAI, 1, 0, 0);
        step(I_JAL, 1, 0, 0);
        step(I_ADDI, 1, 0, 0);

        // Hold across changing instr_d, then stall+flush and flush alone.
        step(I_BLTU, 1, 0, 0);
        step(I_LUI, 1, 1, 0);
        step(I_SW, 1, 1, 0);
        chk("stall_hold", {28'h0, a_alu}, 32'h6);
        step(I_LUI, 1, 1, 1);
        chk("stallflush_bubble", {31'h0, a_valid}, 32'd0);
        step(I_LUI, 1, 0, 1);

        // Illegal handling and counter saturation.
        step(I_MUL, 1, 0, 0);
        chk("mul_a_illegal", {30'h0, a_ill, a_rw}, 32'b10);
        chk("mul_a_cnt", {30'h0, a_cnt}, 32'd1);
        chk("mul_b_alu", {27'h0, b_alu}, 32'b01011);
        step(I_BAD, 0, 0, 0);
        chk("bad_immsrc", {29'h0, a_imm}, 32'd7);
        chk("invalid_no_ill", {31'h0, a_ill}, 32'd0);
        step(I_BAD, 1, 1, 0);
        step(I_BAD, 1, 0, 1);
        step(I_LDX, 1, 0, 0);
        step(I_BRX, 1, 0, 0);
        step(I_SLLX, 1, 0, 0);
        step(I_BAD, 1, 0, 0);
        chk("a_cnt_sat", {30'h0, a_cnt}, 32'd3);
        chk("b_cnt", {24'h0, b_cnt}, 32'd4);

        // Asynchronous reset mid-cycle, held for 3 cycles.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", {30'h0, a_cnt}, 32'd0);
        chk("async_rst_valid", {30'h0, a_valid, a_ill}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(I_SUB, 1, 0, 0);
        step(I_BLTU, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
